voice_allocator: RTL

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// ---------------------------------------------------------------------------
// voice_allocator
//
// Assigns incoming MIDI-style note events to a fixed pool of synth voices.
// Each accepted event walks a three-state FSM:
//   IDLE  : ev_ready high, event captured on the accepting edge
//   SCAN  : voice selection is computed and registered
//   APPLY : per-voice state is committed; the update pulse appears next cycle
//
// Voice choice for NOTE_ON, first match wins:
//   retrigger of a gated voice with the same note and channel,
//   lowest idle voice whose envelope is free,
//   lowest ungated voice,
//   steal the oldest voice (ties go to the lowest index).
//
// Optional feature macro: VOICE_ALLOC_SUSTAIN_EN
//   Defined   : SUSTAIN events drive a per-channel pedal. A NOTE_OFF on a
//               pedalled channel only marks the voice sustained. Releasing
//               the pedal gates off every sustained voice on that channel.
//   Undefined : SUSTAIN events are accepted and dropped. No pedal state exists.
//
// Ports
//   CLOCK_50     : clock, all state changes on its rising edge
//   reset_reg    : synchronous active-high reset
//   ev_valid / ev_ready : event handshake, transfer when both are high
//   ev_type      : 0 NOTE_ON, 1 NOTE_OFF, 2 ALL_OFF, 3 SUSTAIN
//   ev_chan, ev_note, ev_vel : event channel, note and velocity/pedal value
//   chan_mask    : per-channel enable, bit n enables channel n
//   voice_free   : per-voice "envelope idle" flag from the engine
//   key_on       : per-voice gate
//   upd_valid    : one-cycle update pulse
//   upd_voice, upd_note, upd_vel, upd_on : contents of the update
//   active_keys  : number of gated voices
// ---------------------------------------------------------------------------
module voice_allocator #(
  parameter int VOICES = 8,
  parameter int AGE_W  = 4
) (
  input  logic                        CLOCK_50,
  input  logic                        reset_reg,
  input  logic                        ev_valid,
  output logic                        ev_ready,
  input  logic [1:0]                  ev_type,
  input  logic [3:0]                  ev_chan,
  input  logic [6:0]                  ev_note,
  input  logic [6:0]                  ev_vel,
  input  logic [15:0]                 chan_mask,
  input  logic [VOICES-1:0]           voice_free,
  output logic [VOICES-1:0]           key_on,
  output logic                        upd_valid,
  output logic [$clog2(VOICES)-1:0]   upd_voice,
  output logic [6:0]                  upd_note,
  output logic [6:0]                  upd_vel,
  output logic                        upd_on,
  output logic [$clog2(VOICES+1)-1:0] active_keys
);

  localparam int VW = $clog2(VOICES);
  localparam int KW = $clog2(VOICES + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  localparam logic [1:0] EV_ON  = 2'd0;
  localparam logic [1:0] EV_OFF = 2'd1;
  localparam logic [1:0] EV_ALL = 2'd2;
  localparam logic [1:0] EV_SUS = 2'd3;

  typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_t;

  // Action decided in SCAN and carried out in APPLY.
  typedef enum logic [2:0] {
    ACT_NONE, ACT_ON, ACT_OFF, ACT_MARK, ACT_ALL, ACT_PEDAL_ON, ACT_PEDAL_OFF
  } act_t;

  state_t            state_reg;
  act_t              act_reg;
  act_t              act_next;
  logic              ev_ready_reg;

  logic [1:0]        cap_type_reg;
  logic [3:0]        cap_chan_reg;
  logic [6:0]        cap_note_reg;
  logic [6:0]        cap_vel_reg;
  logic              cap_en_reg;

  logic [VW-1:0]     sel_reg;
  logic [VW-1:0]     sel_next;
  logic [VOICES-1:0] clr_reg;
  logic [VOICES-1:0] clr_next;

  logic              upd_valid_reg;
  logic [VW-1:0]     upd_voice_reg;
  logic [6:0]        upd_note_reg;
  logic [6:0]        upd_vel_reg;
  logic              upd_on_reg;

  // Flattened view of the per-voice registers.
  logic [VOICES-1:0] key_vec;
  logic [VOICES-1:0] held_vec;
  logic [6:0]        note_arr [VOICES];
  logic [3:0]        chan_arr [VOICES];
  logic [AGE_W-1:0]  age_arr  [VOICES];

  logic              apply_on;
  logic              apply_clr;

  // Scan intermediates.
  logic [1:0]        eff_type;
  logic              retrig_hit;
  logic              idle_hit;
  logic              unkey_hit;
  logic              off_hit;
  logic [VW-1:0]     retrig_idx;
  logic [VW-1:0]     idle_idx;
  logic [VW-1:0]     unkey_idx;
  logic [VW-1:0]     off_idx;
  logic [VW-1:0]     old_idx;
  logic [AGE_W-1:0]  old_age;
  logic [VOICES-1:0] chan_hits;
  logic [KW-1:0]     key_count;

`ifdef VOICE_ALLOC_SUSTAIN_EN
  logic [VOICES-1:0] sus_vec;
  logic [VOICES-1:0] sus_hits;
  logic [VW-1:0]     sus_idx;
  logic [15:0]       pedal_reg;
  logic              apply_mark;

  assign apply_mark = (state_reg == APPLY) && (act_reg == ACT_MARK);
  // A voice already held only by the pedal must not absorb another NOTE_OFF.
  assign held_vec   = key_vec & ~sus_vec;
`else
  assign held_vec   = key_vec;
`endif

  assign apply_on  = (state_reg == APPLY) && (act_reg == ACT_ON);
  assign apply_clr = (state_reg == APPLY) &&
                     ((act_reg == ACT_OFF) || (act_reg == ACT_ALL) ||
                      (act_reg == ACT_PEDAL_OFF));

  // -------------------------------------------------------------------------
  // Per-voice state: gate, note, channel, age (and sustain flag).
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < VOICES; gi++) begin : g_voice
      logic             key_reg;
      logic [6:0]       note_reg;
      logic [3:0]       chan_reg;
      logic [AGE_W-1:0] age_reg;

      always_ff @(posedge CLOCK_50) begin
        if (reset_reg) begin
          key_reg  <= 1'b0;
          note_reg <= '0;
          chan_reg <= '0;
          age_reg  <= '0;
        end else if (apply_on) begin
          // Every NOTE_ON ages the whole pool; the chosen voice restarts at 0.
          if (sel_reg == VW'(gi)) begin
            key_reg  <= 1'b1;
            note_reg <= cap_note_reg;
            chan_reg <= cap_chan_reg;
            age_reg  <= '0;
          end else if (age_reg != AGE_MAX) begin
            age_reg <= age_reg + 1'b1;
          end
        end else if (apply_clr && clr_reg[gi]) begin
          key_reg <= 1'b0;
        end
      end

      assign key_vec[gi]  = key_reg;
      assign note_arr[gi] = note_reg;
      assign chan_arr[gi] = chan_reg;
      assign age_arr[gi]  = age_reg;

`ifdef VOICE_ALLOC_SUSTAIN_EN
      logic sus_reg;

      always_ff @(posedge CLOCK_50) begin
        if (reset_reg) begin
          sus_reg <= 1'b0;
        end else if (apply_on && (sel_reg == VW'(gi))) begin
          sus_reg <= 1'b0;
        end else if (apply_clr && clr_reg[gi]) begin
          sus_reg <= 1'b0;
        end else if (apply_mark && clr_reg[gi]) begin
          sus_reg <= 1'b1;
        end
      end

      assign sus_vec[gi] = sus_reg;
`endif
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Voice selection, evaluated while in SCAN.
  // -------------------------------------------------------------------------
  always_comb begin
    act_next   = ACT_NONE;
    sel_next   = '0;
    clr_next   = '0;
    eff_type   = ((cap_type_reg == EV_ON) && (cap_vel_reg == 7'd0)) ? EV_OFF : cap_type_reg;
    retrig_hit = 1'b0;
    idle_hit   = 1'b0;
    unkey_hit  = 1'b0;
    off_hit    = 1'b0;
    retrig_idx = '0;
    idle_idx   = '0;
    unkey_idx  = '0;
    off_idx    = '0;
    chan_hits  = '0;

    // Walking downward leaves the lowest matching index in each slot.
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (key_vec[i] && (note_arr[i] == cap_note_reg) && (chan_arr[i] == cap_chan_reg)) begin
        retrig_hit = 1'b1;
        retrig_idx = VW'(i);
      end
      if (held_vec[i] && (note_arr[i] == cap_note_reg) && (chan_arr[i] == cap_chan_reg)) begin
        off_hit = 1'b1;
        off_idx = VW'(i);
      end
      if (!key_vec[i] && voice_free[i]) begin
        idle_hit = 1'b1;
        idle_idx = VW'(i);
      end
      if (!key_vec[i]) begin
        unkey_hit = 1'b1;
        unkey_idx = VW'(i);
      end
      chan_hits[i] = key_vec[i] && (chan_arr[i] == cap_chan_reg);
    end

    // Strict compare keeps the lowest index among equally old voices.
    old_idx = '0;
    old_age = age_arr[0];
    for (int i = 1; i < VOICES; i++) begin
      if (age_arr[i] > old_age) begin
        old_age = age_arr[i];
        old_idx = VW'(i);
      end
    end

`ifdef VOICE_ALLOC_SUSTAIN_EN
    sus_hits = '0;
    sus_idx  = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      sus_hits[i] = sus_vec[i] && (chan_arr[i] == cap_chan_reg);
      if (sus_hits[i]) begin
        sus_idx = VW'(i);
      end
    end
`endif

    if (cap_en_reg) begin
      case (eff_type)
        EV_ON: begin
          act_next = ACT_ON;
          if (retrig_hit) begin
            sel_next = retrig_idx;
          end else if (idle_hit) begin
            sel_next = idle_idx;
          end else if (unkey_hit) begin
            sel_next = unkey_idx;
          end else begin
            sel_next = old_idx;
          end
        end
        EV_OFF: begin
          if (off_hit) begin
            sel_next          = off_idx;
            clr_next[off_idx] = 1'b1;
`ifdef VOICE_ALLOC_SUSTAIN_EN
            act_next = pedal_reg[cap_chan_reg] ? ACT_MARK : ACT_OFF;
`else
            act_next = ACT_OFF;
`endif
          end
        end
        EV_ALL: begin
          clr_next = chan_hits;
          if (|chan_hits) begin
            act_next = ACT_ALL;
          end
        end
        EV_SUS: begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
          if (cap_vel_reg[6]) begin
            act_next = ACT_PEDAL_ON;
          end else begin
            act_next = ACT_PEDAL_OFF;
            clr_next = sus_hits;
            sel_next = sus_idx;
          end
`endif
        end
        default: act_next = ACT_NONE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered handshake and update outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (reset_reg) begin
      state_reg     <= IDLE;
      ev_ready_reg  <= 1'b0;
      cap_type_reg  <= '0;
      cap_chan_reg  <= '0;
      cap_note_reg  <= '0;
      cap_vel_reg   <= '0;
      cap_en_reg    <= 1'b0;
      act_reg       <= ACT_NONE;
      sel_reg       <= '0;
      clr_reg       <= '0;
      upd_valid_reg <= 1'b0;
      upd_voice_reg <= '0;
      upd_note_reg  <= '0;
      upd_vel_reg   <= '0;
      upd_on_reg    <= 1'b0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
      pedal_reg     <= '0;
`endif
    end else begin
      upd_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          ev_ready_reg <= 1'b1;
          if (ev_valid && ev_ready_reg) begin
            cap_type_reg <= ev_type;
            cap_chan_reg <= ev_chan;
            cap_note_reg <= ev_note;
            cap_vel_reg  <= ev_vel;
            cap_en_reg   <= chan_mask[ev_chan];
            ev_ready_reg <= 1'b0;
            state_reg    <= SCAN;
          end
        end
        SCAN: begin
          act_reg   <= act_next;
          sel_reg   <= sel_next;
          clr_reg   <= clr_next;
          state_reg <= APPLY;
        end
        APPLY: begin
          state_reg    <= IDLE;
          ev_ready_reg <= 1'b1;
          case (act_reg)
            ACT_ON: begin
              upd_valid_reg <= 1'b1;
              upd_voice_reg <= sel_reg;
              upd_note_reg  <= cap_note_reg;
              upd_vel_reg   <= cap_vel_reg;
              upd_on_reg    <= 1'b1;
            end
            ACT_OFF: begin
              upd_valid_reg <= 1'b1;
              upd_voice_reg <= sel_reg;
              upd_note_reg  <= cap_note_reg;
              upd_vel_reg   <= cap_vel_reg;
              upd_on_reg    <= 1'b0;
            end
            ACT_ALL: begin
              upd_valid_reg <= 1'b1;
              upd_voice_reg <= '0;
              upd_note_reg  <= '0;
              upd_vel_reg   <= '0;
              upd_on_reg    <= 1'b0;
            end
`ifdef VOICE_ALLOC_SUSTAIN_EN
            ACT_PEDAL_ON: begin
              pedal_reg[cap_chan_reg] <= 1'b1;
            end
            ACT_PEDAL_OFF: begin
              pedal_reg[cap_chan_reg] <= 1'b0;
              if (|clr_reg) begin
                upd_valid_reg <= 1'b1;
                upd_voice_reg <= sel_reg;
                upd_note_reg  <= note_arr[sel_reg];
                upd_vel_reg   <= '0;
                upd_on_reg    <= 1'b0;
              end
            end
`endif
            default: begin
            end
          endcase
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Popcount of the registered gates, so it tracks key_on in the same cycle.
  always_comb begin
    key_count = '0;
    for (int i = 0; i < VOICES; i++) begin
      key_count = key_count + KW'(key_vec[i]);
    end
  end

  assign ev_ready    = ev_ready_reg;
  assign key_on      = key_vec;
  assign upd_valid   = upd_valid_reg;
  assign upd_voice   = upd_voice_reg;
  assign upd_note    = upd_note_reg;
  assign upd_vel     = upd_vel_reg;
  assign upd_on      = upd_on_reg;
  assign active_keys = key_count;

endmodule
